ff_cascada_param: RTL and testbench

//   Parametrised cascade of DEPTH registered stages, each WIDTH bits wide.

---
 rtl/ff_cascada_param.sv | 115 +++++++++++
 tb/tb_ff_cascada_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ff_cascada_param.sv
// ---------------------------------------------------------------------------
// ff_cascada_param
//   Parametrised cascade of DEPTH registered stages, each WIDTH bits wide.
//   Used as the generic delay line / operand shifter of the Booth datapath.
//   Supports forward and backward serial shifting, parallel load, hold and a
//   synchronous flush. A saturating fill counter tracks how many entries have
//   been written since the last reset or flush.
//
// Ports
//   CLK        in   1            rising-edge clock
//   rst        in   1            synchronous reset, active-low
//   flush      in   1            synchronous clear of stages and counter
//   en         in   1            shift/load enable
//   mode       in   2            00 hold, 01 shift fwd, 10 shift bwd, 11 load
//   din        in   WIDTH        serial data in
//   load_data  in   WIDTH*DEPTH  parallel load, stage i at [i*WIDTH +: WIDTH]
//   taps       out  WIDTH*DEPTH  all stages, stage i at [i*WIDTH +: WIDTH]
//   dout       out  WIDTH        last stage (forward output end)
//   count      out  CW           entries written, saturating at DEPTH
//   full       out  1            count == DEPTH
//   empty      out  1            count == 0
//
// Every output comes straight from a register or is decoded from the
// counter register; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ff_cascada_param #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [WIDTH-1:0]       dout,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty
);

  generate
    if ((DEPTH < 2) || (WIDTH < 1)) begin : g_param_err
      $error("ff_cascada_param: illegal parameters (need DEPTH>=2, WIDTH>=1)");
    end
  endgenerate

  localparam int                 TOTAL_W  = WIDTH * DEPTH;
  localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_BWD  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [TOTAL_W-1:0] stage_q, stage_d;
  logic [CW-1:0]      count_q, count_d;

  // Counter stops at DEPTH instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == FULL_CNT) ? c : c + CW'(1);
  endfunction

  always_comb begin
    stage_d = stage_q;
    count_d = count_q;
    if (flush) begin
      stage_d = '0;
      count_d = '0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_FWD: begin
          // Stage 0 sits in the low slice, so forward is a left shift by WIDTH.
          stage_d = {stage_q[TOTAL_W-WIDTH-1:0], din};
          count_d = sat_inc(count_q);
        end
        MODE_BWD: begin
          stage_d = {din, stage_q[TOTAL_W-1:WIDTH]};
          count_d = sat_inc(count_q);
        end
        MODE_LOAD: begin
          stage_d = load_data;
          count_d = FULL_CNT;
        end
        default: begin
          stage_d = stage_q;
          count_d = count_q;
        end
      endcase
    end
  end

  // Register stage: reset dominates flush, which is folded into the _d logic.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      stage_q <= '0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      count_q <= count_d;
    end
  end

  assign taps  = stage_q;
  assign dout  = stage_q[TOTAL_W-1 -: WIDTH];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_ff_cascada_param.sv
module tb_ff_cascada_param;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared control, separate data for the 8-bit and 1-bit instances.
  logic        rst, flush, en;
  logic [1:0]  mode;
  logic [7:0]  din8;
  logic [31:0] ld8;
  logic        din1;
  logic [3:0]  ld1;

  logic [31:0] taps8;
  logic [7:0]  dout8;
  logic [2:0]  cnt8;
  logic        full8, empty8;
  logic [3:0]  taps1;
  logic        dout1;
  logic [2:0]  cnt1;
  logic        full1, empty1;

  ff_cascada_param #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .CLK(CLK), .rst(rst), .flush(flush), .en(en), .mode(mode),
    .din(din8), .load_data(ld8), .taps(taps8), .dout(dout8),
    .count(cnt8), .full(full8), .empty(empty8)
  );

  ff_cascada_param #(.WIDTH(1), .DEPTH(4)) u_dut1 (
    .CLK(CLK), .rst(rst), .flush(flush), .en(en), .mode(mode),
    .din(din1), .load_data(ld1), .taps(taps1), .dout(dout1),
    .count(cnt1), .full(full1), .empty(empty1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each stage is an array element, count an integer.
  logic [7:0] m8 [4];
  logic       m1 [4];
  int         mcnt;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m8[i] = '0;
      m1[i] = 1'b0;
    end
    mcnt = 0;
  endtask

  task automatic model_step();
    if (!rst || flush) begin
      model_clear();
    end else if (en) begin
      case (mode)
        2'b01: begin
          for (int i = 3; i > 0; i--) begin
            m8[i] = m8[i-1];
            m1[i] = m1[i-1];
          end
          m8[0] = din8;
          m1[0] = din1;
          mcnt  = (mcnt < 4) ? mcnt + 1 : 4;
        end
        2'b10: begin
          for (int i = 0; i < 3; i++) begin
            m8[i] = m8[i+1];
            m1[i] = m1[i+1];
          end
          m8[3] = din8;
          m1[3] = din1;
          mcnt  = (mcnt < 4) ? mcnt + 1 : 4;
        end
        2'b11: begin
          for (int i = 0; i < 4; i++) begin
            m8[i] = ld8[i*8 +: 8];
            m1[i] = ld1[i];
          end
          mcnt = 4;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    logic [31:0] e8;
    logic [3:0]  e1;
    for (int i = 0; i < 4; i++) begin
      e8[i*8 +: 8] = m8[i];
      e1[i]        = m1[i];
    end
    chk("taps8",  taps8,  e8);
    chk("dout8",  dout8,  m8[3]);
    chk("count8", cnt8,   mcnt);
    chk("full8",  full8,  (mcnt == 4));
    chk("empty8", empty8, (mcnt == 0));
    chk("taps1",  taps1,  e1);
    chk("dout1",  dout1,  m1[3]);
    chk("count1", cnt1,   mcnt);
    chk("full1",  full1,  (mcnt == 4));
    chk("empty1", empty1, (mcnt == 0));
  endtask

  // Apply one edge: the model advances with the inputs present at the edge,
  // then outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    model_clear();
    rst = 1'b0; flush = 1'b0; en = 1'b1; mode = 2'b01;
    din8 = 8'hFF; din1 = 1'b1; ld8 = '0; ld1 = '0;

    // Reset held for 3 edges while trying to shift in all-ones.
    repeat (3) tick();
    chk("rst_taps8", taps8, 32'h0);
    chk("rst_taps1", taps1, 4'h0);
    chk("rst_empty", empty8, 1'b1);
    chk("rst_full",  full8,  1'b0);

    // Single 1 walks through the 1-bit cascade; fill counter saturates.
    rst = 1'b1;
    for (int t = 0; t < 6; t++) begin
      din1 = (t == 0);
      din8 = 8'($urandom);
      tick();
      chk("walk_taps", taps1, (t < 4) ? (4'h1 << t) : 4'h0);
      chk("walk_dout", dout1, (t == 3));
      chk("fill_cnt",  cnt8,  (t < 3) ? t + 1 : 4);
      chk("fill_full", full8, (t >= 3));
      chk("fill_empty", empty8, 1'b0);
    end

    // Parallel load then one backward shift.
    mode = 2'b11; ld8 = 32'h44332211; ld1 = 4'b1010;
    tick();
    mode = 2'b10; din8 = 8'hAA; din1 = 1'b0;
    tick();
    chk("bwd_taps8", taps8, 32'hAA443322);
    chk("bwd_cnt",   cnt8,  3'd4);

    // Disabled load must not disturb anything; flush acts with en low.
    en = 1'b0; mode = 2'b11; ld8 = 32'hDEADBEEF; ld1 = 4'b0101;
    tick();
    chk("hold_taps8", taps8, 32'hAA443322);
    flush = 1'b1;
    tick();
    chk("flush_taps8", taps8, 32'h0);
    chk("flush_cnt",   cnt8,  3'd0);
    chk("flush_empty", empty8, 1'b1);
    flush = 1'b0;

    // Reset with flush mid forward burst, then resume from zero.
    en = 1'b1; mode = 2'b01;
    repeat (3) begin
      din8 = 8'($urandom); din1 = 1'($urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b1;
    tick();
    chk("midrst_taps8", taps8, 32'h0);
    chk("midrst_cnt",   cnt8,  3'd0);
    rst = 1'b1; flush = 1'b0; din8 = 8'h5C; din1 = 1'b1;
    tick();
    chk("resume_cnt",  cnt8,  3'd1);
    chk("resume_taps", taps8, 32'h0000005C);

    // Randomised operation against the model.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 19) == 0);
      en    = ($urandom_range(0, 4) != 0);
      mode  = 2'($urandom);
      din8  = 8'($urandom);
      din1  = 1'($urandom);
      ld8   = $urandom;
      ld1   = 4'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
